// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write buffer between the CPU memory stage and the data
//               memory. Stores are queued without stalling the CPU and drained
//               in FIFO order whenever memory is free. Loads bypass queued
//               stores unless they hit a buffered word; a hit load waits until
//               every matching store has drained.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1   system clock, all state on posedge
//   reset          in   1   synchronous, active-high
//   cpu_addr       in   32  byte address from MEM stage
//   cpu_wdata      in   32  store data
//   cpu_memwrite   in   1   store request, held until cpu_stall low
//   cpu_memread    in   1   load request, held until cpu_stall low
//   cpu_sign_mask  in   4   access size/sign code, passed through unchanged
//   cpu_rdata      out  32  load result, registered
//   cpu_stall      out  1   CPU must hold MEM stage this cycle
//   mem_addr       out  32  address to data memory
//   mem_wdata      out  32  write data to data memory
//   mem_memwrite   out  1   one-cycle write request
//   mem_memread    out  1   one-cycle read request
//   mem_sign_mask  out  4   sign/size code to data memory
//   mem_rdata      in   32  read data from data memory
//   mem_busy       in   1   high while a memory request is in progress
//   sb_empty       out  1   no buffered stores and engine idle
// ============================================================================
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_memwrite,
   input  logic        cpu_memread,
   input  logic [3:0]  cpu_sign_mask,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_memwrite,
   output logic        mem_memread,
   output logic [3:0]  mem_sign_mask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy,
   output logic        sb_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE_RD  = 3'd1,
      ST_ISSUE_WR  = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic            is_rd_q, is_rd_d;          // in-flight request is a load
   logic [31:0]     req_addr_q, req_addr_d;
   logic [31:0]     req_wdata_q, req_wdata_d;
   logic [3:0]      req_mask_q, req_mask_d;
   logic            load_done_q, load_done_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

   logic [31:0]     fifo_addr_q  [DEPTH];
   logic [31:0]     fifo_wdata_q [DEPTH];
   logic [3:0]      fifo_mask_q  [DEPTH];

   // -------------------------------------------------------------------------
   // FIFO status and load-hit detection
   // -------------------------------------------------------------------------
   logic             full;
   logic             enq;
   logic             deq;
   logic             hit;
   logic             load_pending;
   logic [DEPTH-1:0] hit_vec;

   assign full = (count_q == C_DEPTH);
   assign enq  = cpu_memwrite & ~full;
   // The head entry is only removed once its write has fully completed, so an
   // in-flight store still counts toward hits until memory drops busy.
   assign deq  = (state_q == ST_WAIT_DONE) & ~is_rd_q & ~mem_busy;

   // An entry is live when its distance from the read pointer is below count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PW-1:0] age;
      assign age         = PW'(gi) - rd_ptr_q;
      assign hit_vec[gi] = ({1'b0, age} < count_q) &&
                           (fifo_addr_q[gi][31:2] == cpu_addr[31:2]);
   end

   assign hit = |hit_vec;

   // load_done masks the load for the single cycle in which the CPU is
   // released, so the still-asserted cpu_memread is not issued a second time.
   assign load_pending = cpu_memread & ~hit & ~load_done_q;

   // -------------------------------------------------------------------------
   // Pointer / count next state
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // Memory engine next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      is_rd_d     = is_rd_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_mask_d  = req_mask_q;
      load_done_d = 1'b0;
      rdata_d     = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (!mem_busy) begin
               if (load_pending) begin
                  // Loads take priority over draining non-matching stores.
                  state_d     = ST_ISSUE_RD;
                  is_rd_d     = 1'b1;
                  req_addr_d  = cpu_addr;
                  req_wdata_d = 32'h0;
                  req_mask_d  = cpu_sign_mask;
               end else if (count_q != '0) begin
                  state_d     = ST_ISSUE_WR;
                  is_rd_d     = 1'b0;
                  req_addr_d  = fifo_addr_q[rd_ptr_q];
                  req_wdata_d = fifo_wdata_q[rd_ptr_q];
                  req_mask_d  = fifo_mask_q[rd_ptr_q];
               end
            end
         end
         ST_ISSUE_RD,
         ST_ISSUE_WR: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (mem_busy) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!mem_busy) begin
               state_d = ST_IDLE;
               if (is_rd_q) begin
                  rdata_d     = mem_rdata;
                  load_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         is_rd_q     <= 1'b0;
         req_addr_q  <= 32'h0;
         req_wdata_q <= 32'h0;
         req_mask_q  <= 4'h0;
         load_done_q <= 1'b0;
         rdata_q     <= 32'h0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         is_rd_q     <= is_rd_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_mask_q  <= req_mask_d;
         load_done_q <= load_done_d;
         rdata_q     <= rdata_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Entry storage needs no reset: liveness is governed by count/pointers.
   always_ff @(posedge clk) begin
      if (enq && !reset) begin
         fifo_addr_q[wr_ptr_q]  <= cpu_addr;
         fifo_wdata_q[wr_ptr_q] <= cpu_wdata;
         fifo_mask_q[wr_ptr_q]  <= cpu_sign_mask;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs; reset is synchronous, so outputs are also gated by reset to be
   // quiet during the very first reset cycle.
   // -------------------------------------------------------------------------
   assign cpu_rdata     = rdata_q;
   assign cpu_stall     = ~reset & ((cpu_memwrite & full) | (cpu_memread & ~load_done_q));
   assign mem_addr      = reset ? 32'h0 : req_addr_q;
   assign mem_wdata     = reset ? 32'h0 : req_wdata_q;
   assign mem_sign_mask = reset ? 4'h0  : req_mask_q;
   assign mem_memwrite  = ~reset & (state_q == ST_ISSUE_WR);
   assign mem_memread   = ~reset & (state_q == ST_ISSUE_RD);
   assign sb_empty      = reset | ((count_q == '0) & (state_q == ST_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench for store_buffer. A small data
//               memory model answers requests with a busy window; expected
//               memory transactions are queued as stimulus is driven and
//               compared as the DUT issues them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int TMO   = 300;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_memwrite;
   logic        cpu_memread;
   logic [3:0]  cpu_sign_mask;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_memwrite;
   logic        mem_memread;
   logic [3:0]  mem_sign_mask;
   logic [31:0] mem_rdata;
   logic        mem_busy;
   logic        sb_empty;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_memwrite  (cpu_memwrite),
      .cpu_memread   (cpu_memread),
      .cpu_sign_mask (cpu_sign_mask),
      .cpu_rdata     (cpu_rdata),
      .cpu_stall     (cpu_stall),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_memwrite  (mem_memwrite),
      .mem_memread   (mem_memread),
      .mem_sign_mask (mem_sign_mask),
      .mem_rdata     (mem_rdata),
      .mem_busy      (mem_busy),
      .sb_empty      (sb_empty)
   );

   int total = 0;
   int bad   = 0;

   // ------------------------------------------------------------------------
   // Data memory model: a request raises busy for three cycles starting the
   // next cycle. hold_busy forces busy high; no_resp ignores requests.
   // ------------------------------------------------------------------------
   logic        hold_busy = 1'b0;
   logic        no_resp   = 1'b0;
   logic        busy_q    = 1'b0;
   logic [1:0]  lat_q     = 2'd0;
   logic [31:0] rdata_q   = 32'h0;
   logic [31:0] mem_arr   [4096];
   logic [4095:0] written = '0;

   assign mem_busy  = busy_q | hold_busy;
   assign mem_rdata = rdata_q;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return 32'h5A00_0000 ^ {a[31:2], 2'b00};
   endfunction

   always @(posedge clk) begin
      if (!reset && !no_resp && (mem_memwrite || mem_memread)) begin
         busy_q <= 1'b1;
         lat_q  <= 2'd2;
         if (mem_memwrite) begin
            mem_arr[mem_addr[13:2]] <= mem_wdata;
            written[mem_addr[13:2]] <= 1'b1;
         end else begin
            rdata_q <= written[mem_addr[13:2]] ? mem_arr[mem_addr[13:2]]
                                               : init_word(mem_addr);
         end
      end else if (busy_q) begin
         if (lat_q == 2'd0) busy_q <= 1'b0;
         else               lat_q  <= lat_q - 2'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Scoreboard of expected memory transactions
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } txn_t;

   txn_t exp_q[$];
   int   wr_seen = 0;
   int   rd_seen = 0;

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      exp_q.push_back('{wr: 1'b1, addr: a, data: d, mask: m});
   endtask

   task automatic push_rd(input logic [31:0] a, input logic [3:0] m);
      exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0, mask: m});
   endtask

   always @(negedge clk) begin
      if (!reset && (mem_memwrite || mem_memread)) begin
         txn_t e;
         if (mem_memwrite) wr_seen++;
         else              rd_seen++;
         total++;
         assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL txn_extra: observed wr=%0b addr=%h, expected no request",
                   mem_memwrite, mem_addr);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert ((mem_memwrite === e.wr) && (mem_memread === !e.wr) &&
                    (mem_addr === e.addr) && (mem_sign_mask === e.mask) &&
                    (!e.wr || (mem_wdata === e.data))) else begin
               bad++;
               $error("FAIL txn_order: observed wr=%0b addr=%h data=%h mask=%h expected wr=%0b addr=%h data=%h mask=%h",
                      mem_memwrite, mem_addr, mem_wdata, mem_sign_mask,
                      e.wr, e.addr, e.data, e.mask);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic timeout(input string tag);
      total++;
      bad++;
      $error("FAIL %s: observed=timeout expected=completion", tag);
   endtask

   task automatic cpu_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, output int stalls);
      @(negedge clk);
      cpu_addr      = a;
      cpu_wdata     = d;
      cpu_sign_mask = m;
      cpu_memwrite  = 1'b1;
      #1;
      stalls = 0;
      while (cpu_stall && stalls < TMO) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (stalls >= TMO) timeout("store_timeout");
      @(posedge clk);
      #1;
      cpu_memwrite = 1'b0;
   endtask

   task automatic cpu_load(input logic [31:0] a, input logic [3:0] m,
                           output logic [31:0] d, output int stalls);
      @(negedge clk);
      cpu_addr      = a;
      cpu_sign_mask = m;
      cpu_memread   = 1'b1;
      #1;
      stalls = 0;
      while (cpu_stall && stalls < TMO) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (stalls >= TMO) timeout("load_timeout");
      d = cpu_rdata;
      @(posedge clk);
      #1;
      cpu_memread = 1'b0;
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      @(negedge clk);
      #1;
      while (!(sb_empty && exp_q.size() == 0) && n < TMO) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_sb_empty"}, 32'(sb_empty), 32'd1);
      check({tag, "_all_issued"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      int          st;
      int          base;
      logic [31:0] d;

      reset         = 1'b1;
      cpu_addr      = 32'h1000;
      cpu_wdata     = 32'h0;
      cpu_memwrite  = 1'b0;
      cpu_memread   = 1'b1;
      cpu_sign_mask = 4'h0;

      // Reset state; a held load must not stall while reset is high.
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall",     32'(cpu_stall),    32'd0);
      check("rst_sb_empty",  32'(sb_empty),     32'd1);
      check("rst_memwrite",  32'(mem_memwrite), 32'd0);
      check("rst_memread",   32'(mem_memread),  32'd0);
      check("rst_mem_addr",  mem_addr,          32'h0);
      check("rst_mem_wdata", mem_wdata,         32'h0);
      check("rst_mem_mask",  32'(mem_sign_mask), 32'd0);
      check("rst_cpu_rdata", cpu_rdata,         32'h0);
      cpu_memread = 1'b0;
      reset       = 1'b0;

      // 1. Three consecutive stores drain in order without stalling.
      push_wr(32'h1000, 32'hA0A0_0001, 4'hF);
      push_wr(32'h1004, 32'hA0A0_0002, 4'hF);
      push_wr(32'h1008, 32'hA0A0_0003, 4'h3);
      cpu_store(32'h1000, 32'hA0A0_0001, 4'hF, st); check("t1_stall0", st, 0);
      cpu_store(32'h1004, 32'hA0A0_0002, 4'hF, st); check("t1_stall1", st, 0);
      cpu_store(32'h1008, 32'hA0A0_0003, 4'h3, st); check("t1_stall2", st, 0);
      wait_empty("t1");

      // 2. Five stores with memory held busy: only the fifth stalls.
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) push_wr(32'h1100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
      for (int i = 0; i < 4; i++) begin
         cpu_store(32'h1100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, st);
         check("t2_no_stall", st, 0);
      end
      @(negedge clk);
      cpu_addr      = 32'h1110;
      cpu_wdata     = 32'hB000_0004;
      cpu_sign_mask = 4'hF;
      cpu_memwrite  = 1'b1;
      #1;
      check("t2_full_stall", 32'(cpu_stall), 32'd1);
      repeat (3) @(negedge clk);
      #1;
      check("t2_still_stall", 32'(cpu_stall), 32'd1);
      check("t2_no_issue_busy", 32'(wr_seen), 32'd3);
      hold_busy = 1'b0;
      st = 0;
      while (cpu_stall && st < TMO) begin
         @(negedge clk);
         #1;
         st++;
      end
      if (st >= TMO) timeout("t2_release");
      check("t2_after_pop_wr", 32'(wr_seen), 32'd4);
      @(posedge clk);
      #1;
      cpu_memwrite = 1'b0;
      wait_empty("t2");

      // 3. Load hitting a buffered store waits for it, then reads it back.
      push_wr(32'h1010, 32'hDEAD_BEEF, 4'hF);
      push_rd(32'h1012, 4'h5);
      cpu_store(32'h1010, 32'hDEAD_BEEF, 4'hF, st);
      check("t3_store_stall", st, 0);
      cpu_load(32'h1012, 4'h5, d, st);
      check("t3_load_waited", 32'(st > 3), 32'd1);
      check("t3_rdata", d, 32'hDEAD_BEEF);
      wait_empty("t3");

      // 4. Non-matching load bypasses two pending stores.
      hold_busy = 1'b1;
      push_rd(32'h1040, 4'hF);
      push_wr(32'h1000, 32'h1111_1111, 4'hF);
      push_wr(32'h1004, 32'h2222_2222, 4'hF);
      cpu_store(32'h1000, 32'h1111_1111, 4'hF, st);
      cpu_store(32'h1004, 32'h2222_2222, 4'hF, st);
      base = rd_seen;
      fork
         cpu_load(32'h1040, 4'hF, d, st);
         begin
            repeat (3) @(negedge clk);
            hold_busy = 1'b0;
         end
      join
      check("t4_rdata", d, init_word(32'h1040));
      check("t4_one_read", 32'(rd_seen - base), 32'd1);
      wait_empty("t4");

      // 5. Reset while the engine waits for busy with two entries queued.
      no_resp = 1'b1;
      push_wr(32'h3000, 32'hC000_0000, 4'hF);
      cpu_store(32'h3000, 32'hC000_0000, 4'hF, st);
      cpu_store(32'h3004, 32'hC000_0001, 4'hF, st);
      repeat (3) @(negedge clk);
      #1;
      check("t5_busy_pending", 32'(sb_empty), 32'd0);
      base = wr_seen;
      hold_busy = 1'b1;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("t5_rst_empty", 32'(sb_empty), 32'd1);
      reset = 1'b0;
      #1;
      check("t5_post_rst_empty", 32'(sb_empty), 32'd1);
      repeat (4) @(negedge clk);
      #1;
      check("t5_no_drain", 32'(wr_seen - base), 32'd0);
      cpu_store(32'h3008, 32'hC000_0002, 4'hF, st);
      check("t5_store_stall", st, 0);
      repeat (3) @(negedge clk);
      #1;
      check("t5_wait_busy_low", 32'(wr_seen - base), 32'd0);
      no_resp = 1'b0;
      push_wr(32'h3008, 32'hC000_0002, 4'hF);
      hold_busy = 1'b0;
      wait_empty("t5");
      check("t5_one_write", 32'(wr_seen - base), 32'd1);

      // 6. LED store passes through exactly once.
      base = wr_seen;
      push_wr(32'h2000, 32'h0000_00A5, 4'h1);
      cpu_store(32'h2000, 32'h0000_00A5, 4'h1, st);
      wait_empty("t6");
      repeat (4) @(negedge clk);
      check("t6_one_write", 32'(wr_seen - base), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
